// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the read-side and write-side controllers.
package fifo_pkg;
   localparam int ADDR_W    = 4;
   localparam int AE_THRESH = 2;

   typedef logic [ADDR_W:0]   ptr_t;
   typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/almost_empty_flag.sv
// Combinational fill level and empty/almost-empty flags from the two wrap-bit pointers.
module almost_empty_flag #(
   parameter int ADDR_W    = fifo_pkg::ADDR_W,
   parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
   input  logic [ADDR_W:0] w_ptr,
   input  logic [ADDR_W:0] r_ptr,
   output logic [ADDR_W:0] level,
   output logic            empty,
   output logic            almost_empty
);
   localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_THRESH);

   // The wrap bit makes a plain modular difference cover 0..depth, so full is not mistaken for empty.
   assign level        = w_ptr - r_ptr;
   assign empty        = (level == '0);
   assign almost_empty = (level <= AE_LIM);
endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: owns the read pointer, arbitrates pops and flush, and
// reports read-valid, fill level and a sticky underflow.
module fifo_read_ctrl #(
   parameter int ADDR_W    = fifo_pkg::ADDR_W,
   parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   w_ptr,
   input  logic              rd_en,
   input  logic              flush,
   input  logic              clr_err,
   output logic [ADDR_W:0]   r_ptr,
   output logic [ADDR_W-1:0] r_addr,
   output logic              rd_valid,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   level,
   output logic              underflow
);
   // Handshake: a pop is taken in the cycle rd_en is high and the FIFO is non-empty;
   // r_addr is valid in that cycle and rd_valid marks the RAM data one cycle later.
   logic pop_ok;
   logic pop_empty;

   almost_empty_flag #(
      .ADDR_W    (ADDR_W),
      .AE_THRESH (AE_THRESH)
   ) u_flags (
      .w_ptr        (w_ptr),
      .r_ptr        (r_ptr),
      .level        (level),
      .empty        (empty),
      .almost_empty (almost_empty)
   );

   assign pop_ok    = rd_en & ~empty & ~flush;
   assign pop_empty = rd_en &  empty & ~flush;
   assign r_addr    = r_ptr[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         rd_valid  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush)
            r_ptr <= w_ptr;
         else if (pop_ok)
            r_ptr <= r_ptr + 1'b1;
         rd_valid <= pop_ok;
         // A new underflow wins over a simultaneous clear.
         if (pop_empty)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: vector table, directed corner sequences and
// randomized traffic against a pointer-arithmetic reference model.
module tb_fifo_read_ctrl;
   logic       clk;
   logic       rst_n;
   logic [4:0] w_ptr;
   logic       rd_en;
   logic       flush;
   logic       clr_err;
   logic [4:0] r_ptr;
   logic [3:0] r_addr;
   logic       rd_valid;
   logic       empty;
   logic       almost_empty;
   logic [4:0] level;
   logic       underflow;

   int total = 0;
   int bad   = 0;

   fifo_read_ctrl #(.ADDR_W(4), .AE_THRESH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_ptr        (w_ptr),
      .rd_en        (rd_en),
      .flush        (flush),
      .clr_err      (clr_err),
      .r_ptr        (r_ptr),
      .r_addr       (r_addr),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .almost_empty (almost_empty),
      .level        (level),
      .underflow    (underflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] w;
      logic       rd;
      logic       fl;
      logic       clr;
      logic [4:0] r;
      logic       rv;
      logic [4:0] lvl;
      logic       uf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compares every output against an expected read pointer / valid / underflow and the
   // level implied by the w_ptr currently driven.
   task automatic check_all(input string tag, input int exp_r, input int exp_rv, input int exp_uf);
      int exp_lvl;
      exp_lvl = (int'(w_ptr) - exp_r + 64) % 32;
      check({tag, " r_ptr"},        int'(r_ptr),        exp_r);
      check({tag, " r_addr"},       int'(r_addr),       exp_r % 16);
      check({tag, " rd_valid"},     int'(rd_valid),     exp_rv);
      check({tag, " underflow"},    int'(underflow),    exp_uf);
      check({tag, " level"},        int'(level),        exp_lvl);
      check({tag, " empty"},        int'(empty),        int'(exp_lvl == 0));
      check({tag, " almost_empty"}, int'(almost_empty), int'(exp_lvl <= 2));
   endtask

   task automatic drive(input int w, input logic rd, input logic fl, input logic clr);
      w_ptr   = 5'(w);
      rd_en   = rd;
      flush   = fl;
      clr_err = clr;
   endtask

   task automatic cycle();
      @(negedge clk);
   endtask

   int m_r, m_rv, m_uf, m_w, m_lvl, step;
   logic m_rd, m_fl, m_clr;

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      check_all("reset", 0, 0, 0);

      // w_ptr=5, five pops, empty pop, clr_err vs new underflow, clr_err alone
      vecs[0] = '{w:5, rd:1, fl:0, clr:0, r:1, rv:1, lvl:4, uf:0};
      vecs[1] = '{w:5, rd:1, fl:0, clr:0, r:2, rv:1, lvl:3, uf:0};
      vecs[2] = '{w:5, rd:1, fl:0, clr:0, r:3, rv:1, lvl:2, uf:0};
      vecs[3] = '{w:5, rd:1, fl:0, clr:0, r:4, rv:1, lvl:1, uf:0};
      vecs[4] = '{w:5, rd:1, fl:0, clr:0, r:5, rv:1, lvl:0, uf:0};
      vecs[5] = '{w:5, rd:1, fl:0, clr:0, r:5, rv:0, lvl:0, uf:1};
      vecs[6] = '{w:5, rd:1, fl:0, clr:1, r:5, rv:0, lvl:0, uf:1};
      vecs[7] = '{w:5, rd:0, fl:0, clr:1, r:5, rv:0, lvl:0, uf:0};
      vecs[8] = '{w:7, rd:1, fl:0, clr:0, r:6, rv:1, lvl:1, uf:0};
      vecs[9] = '{w:7, rd:0, fl:0, clr:0, r:6, rv:0, lvl:1, uf:0};

      check("pre-pop r_addr", int'(r_addr), 0);
      for (int i = 0; i < 10; i++) begin
         drive(int'(vecs[i].w), vecs[i].rd, vecs[i].fl, vecs[i].clr);
         cycle();
         check_all($sformatf("vec%0d", i), int'(vecs[i].r), int'(vecs[i].rv), int'(vecs[i].uf));
         check($sformatf("vec%0d lvl", i), int'(level), int'(vecs[i].lvl));
      end

      // wrap: park r_ptr at 30, w_ptr=2 (level 4), four pops
      drive(30, 0, 1, 0);
      cycle();
      check_all("flush to 30", 30, 0, 0);
      drive(2, 1, 0, 0);
      check("wrap addr0", int'(r_addr), 14);
      cycle();
      check_all("wrap p1", 31, 1, 0);
      cycle();
      check_all("wrap p2", 0, 1, 0);
      cycle();
      check_all("wrap p3", 1, 1, 0);
      cycle();
      check_all("wrap p4", 2, 1, 0);
      check("wrap empty", int'(empty), 1);

      // full: r_ptr=0, w_ptr=16
      drive(0, 0, 1, 0);
      cycle();
      drive(16, 0, 0, 0);
      #1;
      check("full level", int'(level), 16);
      check("full empty", int'(empty), 0);
      check("full ae", int'(almost_empty), 0);
      cycle();
      check_all("full", 0, 0, 0);

      // level 6, flush beats rd_en; first set up a live rd_valid and underflow=0
      drive(6, 1, 0, 0);
      cycle();
      check_all("pre-flush", 1, 1, 0);
      drive(7, 1, 1, 0);
      #1;
      check("pre-flush level", int'(level), 6);
      cycle();
      check_all("flush", 7, 0, 0);

      // underflow set, then stream, then async reset mid-cycle
      drive(7, 1, 0, 0);
      cycle();
      check_all("uf set", 7, 0, 1);
      drive(12, 1, 0, 0);
      cycle();
      check_all("stream", 8, 1, 1);
      #2;
      rst_n = 1'b0;
      w_ptr = 5'd0;
      #1;
      check_all("async rst", 0, 0, 0);
      cycle();
      rst_n = 1'b1;
      drive(0, 0, 0, 0);
      cycle();
      check_all("after rst", 0, 0, 0);

      // randomized traffic against the reference model
      m_r = 0; m_rv = 0; m_uf = 0; m_w = 0;
      for (int n = 0; n < 400; n++) begin
         m_lvl = (m_w - m_r + 64) % 32;
         step  = $urandom_range(0, 2);
         if (m_lvl + step > 16) step = 0;
         m_w   = (m_w + step) % 32;
         m_rd  = ($urandom_range(0, 99) < 60);
         m_fl  = ($urandom_range(0, 99) < 4);
         m_clr = ($urandom_range(0, 99) < 10);
         drive(m_w, m_rd, m_fl, m_clr);
         m_lvl = (m_w - m_r + 64) % 32;
         if (m_fl) begin
            m_r  = m_w;
            m_rv = 0;
         end else if (m_rd && m_lvl > 0) begin
            m_r  = (m_r + 1) % 32;
            m_rv = 1;
         end else begin
            m_rv = 0;
         end
         if (m_rd && m_lvl == 0 && !m_fl) m_uf = 1;
         else if (m_clr) m_uf = 0;
         cycle();
         check_all($sformatf("rnd%0d", n), m_r, m_rv, m_uf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's synchronous FIFO. It owns the read pointer, accepts pop requests, and drives the RAM read address. It also produces registered read-valid, empty, almost-empty, fill-level and sticky underflow indications. It sits opposite the write-side controller and its almost-full flag: it consumes the write pointer and is the consumer end of the same storage.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W (16).
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- w_ptr  in  ADDR_W+1  write pointer from the write controller, registered on clk, extra MSB is the wrap bit.
- rd_en  in  1  pop request.
- flush  in  1  discard all stored entries.
- clr_err  in  1  clears underflow.
- r_ptr  out  ADDR_W+1  read pointer, with wrap bit, to the write controller's full/almost-full logic.
- r_addr  out  ADDR_W  RAM read address = r_ptr[ADDR_W-1:0].
- rd_valid  out  1  RAM read data valid this cycle.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  ADDR_W+1  entries stored, 0..2**ADDR_W.
- underflow  out  1  sticky, set on a pop attempted while empty.

## Operation
- level = (w_ptr - r_ptr) modulo 2**(ADDR_W+1), unsigned. Full (level == 16) is legal and is distinguished from empty by the wrap bit.
- empty, almost_empty and level are combinational from w_ptr and the registered r_ptr. They have no registered lag.
- pop_ok = rd_en & ~empty & ~flush.
- When pop_ok is true: r_ptr increments by 1 at the next edge and wraps 2**(ADDR_W+1)-1 -> 0. rd_valid = 1 on the following cycle.
- When rd_en & empty & ~flush: no pointer change, rd_valid = 0 next cycle, underflow set.
- flush: r_ptr <= w_ptr at the next edge and rd_valid <= 0. flush beats a simultaneous rd_en, and no underflow is recorded.
- Underflow priority: clr_err and a new underflow in the same cycle leave underflow = 1 (set wins).
- Simultaneous push (w_ptr advancing) and pop: level is unchanged. While empty, a pop in the same cycle as the first push is rejected, because empty is evaluated on the current w_ptr.
- Reset: r_ptr = 0, rd_valid = 0, underflow = 0. Because w_ptr also resets to 0, empty = 1, almost_empty = 1 and level = 0.
- Reset asserted mid-operation clears all registers immediately, independent of clk. An in-flight rd_valid is dropped.
- Counter FSM is implicit in r_ptr. No other state.

## Timing
- Pop-to-pointer latency: 1 cycle.
- Pop-to-rd_valid latency: 1 cycle. This matches the synchronous RAM read: r_addr is presented in the pop cycle and data returns the next cycle with rd_valid.
- Back-to-back pops give one rd_valid per cycle, at full throughput, until empty.
- Flag response to a w_ptr change: same cycle (combinational). Flag response to a pop: the cycle after the edge.
- rd_valid and underflow are registered outputs, glitch-free.

## Structure
- Package fifo_pkg holds:
  - ADDR_W default;
  - typedef ptr_t (logic [ADDR_W:0]);
  - typedef addr_t;
  - AE_THRESH default.
- The write controller also imports fifo_pkg.
- One sub-module, almost_empty_flag: purely combinational, takes w_ptr and r_ptr, outputs level, empty and almost_empty. It is the counterpart of the write side's almost-full generator.
- fifo_read_ctrl holds r_ptr, the rd_valid register, the underflow register and pop arbitration.

## Test plan
- Reset release with w_ptr = 0 -> r_ptr = 0, empty = 1, almost_empty = 1, level = 0, rd_valid = 0, underflow = 0.
- w_ptr = 5, rd_en held for 5 cycles -> r_addr steps 0..4, rd_valid is high for 5 cycles starting one cycle after the first pop, then empty = 1. almost_empty rises when level = 2.
- Wrap: r_ptr = 30, w_ptr = 2 (level 4), then 4 pops -> r_ptr goes 31, 0, 1, 2, r_addr goes 14, 15, 0, 1, empty = 1.
- Full: w_ptr = 16, r_ptr = 0 -> level = 16, empty = 0, almost_empty = 0.
- rd_en while empty -> r_ptr unchanged, rd_valid = 0, underflow = 1. Next, clr_err together with another empty pop -> underflow stays 1. clr_err alone -> underflow = 0.
- level 6, flush together with rd_en -> next cycle r_ptr = w_ptr, empty = 1, rd_valid = 0, underflow = 0. Then rst_n pulsed low mid-stream -> outputs return to reset values asynchronously.
